// File: rtl/pickup_tracker.sv
// Multi-item collectible detector: per-item overlap dwell, lowest-index pickup
// arbitration, per-item cooldown and a goal counter for the game-logic layer.
module pickup_tracker #(
    parameter int N_ITEMS     = 4,
    parameter int POS_W       = 12,
    parameter int PW          = 32,
    parameter int PH          = 32,
    parameter int IW          = 20,
    parameter int IH          = 18,
    parameter int MARGIN      = 5,
    parameter int HOLD_CYCLES = 500,
    parameter int COOLDOWN    = 1000,
    parameter int MAX_COUNT   = 10,
    parameter int CTR_W       = 8,
    parameter int WRAP_MODE   = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           reset,
    input  logic [POS_W-1:0]                               player_x,
    input  logic [POS_W-1:0]                               player_y,
    input  logic [N_ITEMS*POS_W-1:0]                       item_x,
    input  logic [N_ITEMS*POS_W-1:0]                       item_y,
    input  logic [N_ITEMS-1:0]                             item_enable,
    output logic [N_ITEMS-1:0]                             item_active,
    output logic                                           item_taken,
    output logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0] taken_idx,
    output logic [CTR_W-1:0]                               pickup_ctr,
    output logic                                           goal_reached
);

    localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int DW    = $clog2(HOLD_CYCLES + 1);
    localparam int CW    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int EW    = POS_W + 2;

    localparam logic [EW-1:0]    ITEM_X_REACH   = EW'(IW + MARGIN);
    localparam logic [EW-1:0]    ITEM_Y_REACH   = EW'(IH + MARGIN);
    localparam logic [EW-1:0]    PLAYER_X_REACH = EW'(PW + MARGIN);
    localparam logic [EW-1:0]    PLAYER_Y_REACH = EW'(PH + MARGIN);
    localparam logic [DW-1:0]    DWELL_LAST     = DW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0]    DWELL_ONE      = DW'(1);
    localparam logic [CW-1:0]    CD_START       = CW'(COOLDOWN - 1);
    localparam logic [CW-1:0]    CD_ONE         = CW'(1);
    localparam logic [CTR_W-1:0] CTR_LAST       = CTR_W'(MAX_COUNT - 1);
    localparam logic [CTR_W-1:0] CTR_MAX        = CTR_W'(MAX_COUNT);
    localparam logic [CTR_W-1:0] CTR_ONE        = CTR_W'(1);

    // Two guard bits so coordinate plus box extent never wraps.
    function automatic logic boxes_overlap(
        input logic [POS_W-1:0] px,
        input logic [POS_W-1:0] py,
        input logic [POS_W-1:0] ix,
        input logic [POS_W-1:0] iy
    );
        logic [EW-1:0] pxe;
        logic [EW-1:0] pye;
        logic [EW-1:0] ixe;
        logic [EW-1:0] iye;
        pxe = {2'b00, px};
        pye = {2'b00, py};
        ixe = {2'b00, ix};
        iye = {2'b00, iy};
        return (pxe < ixe + ITEM_X_REACH) && (pxe + PLAYER_X_REACH > ixe) &&
               (pye < iye + ITEM_Y_REACH) && (pye + PLAYER_Y_REACH > iye);
    endfunction

    logic               clear_s;
    logic [N_ITEMS-1:0] ov_s;
    logic [N_ITEMS-1:0] cand_s;
    logic               win_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [DW-1:0]      dwell_r    [N_ITEMS];
    logic [CW-1:0]      cooldown_r [N_ITEMS];

    assign clear_s = rst | reset;

    // Overlap and pickup-candidate flags per item
    always_comb begin
        ov_s   = '0;
        cand_s = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            ov_s[i]   = item_enable[i] & item_active[i] &
                        boxes_overlap(player_x, player_y,
                                      item_x[i*POS_W +: POS_W], item_y[i*POS_W +: POS_W]);
            cand_s[i] = ov_s[i] & (dwell_r[i] == DWELL_LAST);
        end
    end

    // Lowest-index candidate wins; scanning downward leaves the lowest index last
    always_comb begin
        win_s     = |cand_s;
        win_idx_s = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            win_idx_s = cand_s[i] ? IDX_W'(i) : win_idx_s;
        end
    end

    // Dwell, cooldown and visibility per item
    always_ff @(posedge clk) begin
        if (clear_s) begin
            item_active <= '1;
            for (int i = 0; i < N_ITEMS; i++) begin
                dwell_r[i]    <= '0;
                cooldown_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (!item_active[i]) begin
                    dwell_r[i] <= '0;
                    if (cooldown_r[i] == '0) begin
                        item_active[i] <= 1'b1;
                    end else begin
                        cooldown_r[i] <= cooldown_r[i] - CD_ONE;
                    end
                end else if (win_s && (win_idx_s == IDX_W'(i))) begin
                    dwell_r[i]     <= '0;
                    item_active[i] <= 1'b0;
                    cooldown_r[i]  <= CD_START;
                end else if (!ov_s[i]) begin
                    dwell_r[i] <= '0;
                end else if (dwell_r[i] != DWELL_LAST) begin
                    dwell_r[i] <= dwell_r[i] + DWELL_ONE;
                end else begin
                    // Losing candidate keeps its full dwell and retries next cycle.
                    dwell_r[i] <= dwell_r[i];
                end
            end
        end
    end

    // Pickup pulse, held index and goal counter
    always_ff @(posedge clk) begin
        if (clear_s) begin
            item_taken   <= 1'b0;
            taken_idx    <= '0;
            pickup_ctr   <= '0;
            goal_reached <= 1'b0;
        end else begin
            item_taken   <= win_s;
            goal_reached <= 1'b0;
            if (win_s) begin
                taken_idx <= win_idx_s;
                if (pickup_ctr == CTR_LAST) begin
                    goal_reached <= 1'b1;
                    pickup_ctr   <= (WRAP_MODE != 0) ? '0 : CTR_MAX;
                end else if (pickup_ctr < CTR_LAST) begin
                    pickup_ctr <= pickup_ctr + CTR_ONE;
                end else begin
                    pickup_ctr <= pickup_ctr;
                end
            end else begin
                taken_idx  <= taken_idx;
                pickup_ctr <= pickup_ctr;
            end
        end
    end

endmodule
